// File: rtl/interrupt_vector_sequencer.sv
// ---------------------------------------------------------------------------
// interrupt_vector_sequencer: reset/NMI/IRQ/BRK entry - stack pushes, vector fetch, PC load
// Rev 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module interrupt_vector_sequencer #(
  parameter logic [15:0] NMI_VECTOR   = 16'hFFFA,
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE,
  parameter logic [7:0]  STACK_PAGE   = 8'h01
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        brk_req,
  input  logic        instr_bound,
  input  logic        i_flag,
  input  logic [7:0]  p_in,
  input  logic [7:0]  pcl_cur,
  input  logic [7:0]  pch_cur,
  input  logic [7:0]  sp_cur,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        sp_dec,
  output logic        pc_load,
  output logic [7:0]  pcl_load,
  output logic [7:0]  pch_load,
  output logic        set_i,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    RST_WAIT = 3'd0,
    IDLE     = 3'd1,
    PUSH_H   = 3'd2,
    PUSH_L   = 3'd3,
    PUSH_P   = 3'd4,
    VEC_L    = 3'd5,
    VEC_H    = 3'd6,
    LOAD     = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    K_RESET = 2'd0,
    K_NMI   = 2'd1,
    K_BRK   = 2'd2,
    K_IRQ   = 2'd3
  } kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic        brk_seen_q, brk_seen_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic        nmi_prev_q, nmi_prev_d;
  logic [7:0]  pcl_load_q, pcl_load_d;
  logic [7:0]  pch_load_q, pch_load_d;

  logic        take_nmi;
  logic        nmi_fall;
  logic [15:0] vec_base;
  logic [7:0]  p_push;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RST_WAIT;
      kind_q     <= K_RESET;
      brk_seen_q <= 1'b0;
      nmi_pend_q <= 1'b0;
      nmi_prev_q <= 1'b1;
      pcl_load_q <= 8'h00;
      pch_load_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      brk_seen_q <= brk_seen_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_prev_q <= nmi_prev_d;
      pcl_load_q <= pcl_load_d;
      pch_load_q <= pch_load_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    brk_seen_d = brk_seen_q;
    pcl_load_d = pcl_load_q;
    pch_load_d = pch_load_q;
    nmi_prev_d = nmi_n;
    nmi_fall   = nmi_prev_q & ~nmi_n;
    take_nmi   = 1'b0;

    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    sp_dec    = 1'b0;
    pc_load   = 1'b0;
    set_i     = 1'b0;
    done      = 1'b0;
    busy      = (state_q != IDLE);

    case (kind_q)
      K_NMI:   vec_base = NMI_VECTOR;
      K_RESET: vec_base = RESET_VECTOR;
      default: vec_base = IRQ_VECTOR;
    endcase

    // Bit 5 always reads as 1 on the stack; bit 4 reflects only a BRK entry.
    p_push = ((p_in | 8'h20) & 8'hEF) | (brk_seen_q ? 8'h10 : 8'h00);

    case (state_q)
      RST_WAIT: state_d = PUSH_H;
      IDLE: begin
        if (instr_bound) begin
          if (nmi_pend_q) begin
            kind_d     = K_NMI;
            brk_seen_d = brk_req;
            take_nmi   = 1'b1;
            state_d    = PUSH_H;
          end else if (brk_req) begin
            kind_d     = K_BRK;
            brk_seen_d = 1'b1;
            state_d    = PUSH_H;
          end else if (!irq_n && !i_flag) begin
            kind_d     = K_IRQ;
            brk_seen_d = 1'b0;
            state_d    = PUSH_H;
          end
        end
      end
      PUSH_H, PUSH_L, PUSH_P: begin
        mem_addr = {STACK_PAGE, sp_cur};
        sp_dec   = 1'b1;
        mem_we   = (kind_q != K_RESET);
        if (state_q == PUSH_H) begin
          mem_wdata = pch_cur;
          state_d   = PUSH_L;
        end else if (state_q == PUSH_L) begin
          mem_wdata = pcl_cur;
          state_d   = PUSH_P;
        end else begin
          mem_wdata = p_push;
          state_d   = VEC_L;
        end
      end
      VEC_L: begin
        mem_addr = vec_base;
        state_d  = VEC_H;
      end
      VEC_H: begin
        mem_addr   = vec_base + 16'd1;
        pcl_load_d = mem_rdata;
        state_d    = LOAD;
      end
      LOAD: begin
        pch_load_d = mem_rdata;
        pc_load    = 1'b1;
        set_i      = 1'b1;
        done       = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = RST_WAIT;
    endcase

    // A new falling edge coinciding with acceptance keeps the NMI pending.
    nmi_pend_d = nmi_fall | (nmi_pend_q & ~take_nmi);
  end

  assign pcl_load = pcl_load_q;
  // High vector byte arrives during LOAD, so it is forwarded alongside pc_load.
  assign pch_load = (state_q == LOAD) ? mem_rdata : pch_load_q;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_vector_sequencer.sv
// ---------------------------------------------------------------------------
// tb_interrupt_vector_sequencer: scoreboard bench for interrupt_vector_sequencer
// Rev 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_interrupt_vector_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        nmi_n, irq_n, brk_req, instr_bound, i_flag;
  logic [7:0]  p_in, pcl_cur, pch_cur, sp_cur, mem_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, pcl_load, pch_load;
  logic        mem_we, sp_dec, pc_load, set_i, busy, done;

  interrupt_vector_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .nmi_n       (nmi_n),
    .irq_n       (irq_n),
    .brk_req     (brk_req),
    .instr_bound (instr_bound),
    .i_flag      (i_flag),
    .p_in        (p_in),
    .pcl_cur     (pcl_cur),
    .pch_cur     (pch_cur),
    .sp_cur      (sp_cur),
    .mem_rdata   (mem_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .sp_dec      (sp_dec),
    .pc_load     (pc_load),
    .pcl_load    (pcl_load),
    .pch_load    (pch_load),
    .set_i       (set_i),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_load;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  int n_vec = 0;
  int n_err = 0;
  int busy_cnt = 0, spd_cnt = 0, we_cnt = 0, ld_cnt = 0;

  logic [7:0] mem [0:65535];
  logic       sp_force;
  logic [7:0] sp_force_val;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory and stack-pointer owner models
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
    if (sp_force) sp_cur <= sp_force_val;
    else if (sp_dec) sp_cur <= sp_cur - 8'd1;
  end

  always @(negedge clk) begin
    if (busy)    busy_cnt++;
    if (sp_dec)  spd_cnt++;
    if (mem_we) begin
      we_cnt++;
      if (sb.size() == 0) check_val("unexpected_write", {16'h0, mem_addr}, 32'h0);
      else begin
        e_mon = sb.pop_front();
        check_val("wr_is_write", {31'h0, e_mon.is_load}, 32'h0);
        check_val("wr_addr", {16'h0, mem_addr}, {16'h0, e_mon.addr});
        check_val("wr_data", {24'h0, mem_wdata}, {24'h0, e_mon.data});
      end
    end
    if (pc_load) begin
      ld_cnt++;
      if (sb.size() == 0) check_val("unexpected_load", {16'h0, pch_load, pcl_load}, 32'h0);
      else begin
        e_mon = sb.pop_front();
        check_val("ld_is_load", {31'h0, e_mon.is_load}, 32'h1);
        check_val("ld_pc", {16'h0, pch_load, pcl_load}, {16'h0, e_mon.addr});
        check_val("ld_set_i", {31'h0, set_i}, 32'h1);
        check_val("ld_done", {31'h0, done}, 32'h1);
      end
    end
  end

  task automatic exp_write(input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.is_load = 1'b0; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  task automatic exp_load(input logic [15:0] pc);
    exp_t e;
    e.is_load = 1'b1; e.addr = pc; e.data = 8'h00;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string tag);
    bit got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) check_val({tag, "_timeout"}, 32'h0, 32'h1);
    #1;
  endtask

  task automatic set_sp(input logic [7:0] v);
    sp_force = 1'b1; sp_force_val = v;
    step();
    sp_force = 1'b0;
  endtask

  int b0, s0, w0, l0;

  initial begin
    mem[16'hFFFA] = 8'hCD; mem[16'hFFFB] = 8'hAB;
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
    mem[16'hFFFE] = 8'h78; mem[16'hFFFF] = 8'h56;
    mem[16'h0000] = 8'h00;
    reset_n = 1'b0; nmi_n = 1'b1; irq_n = 1'b1; brk_req = 1'b0;
    instr_bound = 1'b1; i_flag = 1'b1; p_in = 8'h04;
    pcl_cur = 8'h23; pch_cur = 8'h81;
    sp_force = 1'b1; sp_force_val = 8'hFF;
    repeat (3) step();
    sp_force = 1'b0;

    // Reset state
    check_val("rst_busy", {31'h0, busy}, 32'h1);
    check_val("rst_strobes", {26'h0, mem_we, sp_dec, pc_load, set_i, done, 1'b0}, 32'h0);
    check_val("rst_vec", {16'h0, pch_load, pcl_load}, 32'h0);

    // Reset sequence: three dummy pushes, vector from FFFC
    exp_load(16'h1234);
    b0 = busy_cnt; s0 = spd_cnt; w0 = we_cnt;
    reset_n = 1'b1;
    wait_done("reset");
    check_val("reset_busy_cycles", busy_cnt - b0, 32'd7);
    check_val("reset_sp_dec", spd_cnt - s0, 32'd3);
    check_val("reset_no_we", we_cnt - w0, 32'd0);
    step();
    check_val("reset_idle", {31'h0, busy}, 32'h0);

    // IRQ masked by I flag
    b0 = busy_cnt; s0 = spd_cnt; w0 = we_cnt; l0 = ld_cnt;
    i_flag = 1'b1; irq_n = 1'b0;
    repeat (20) step();
    check_val("masked_busy", busy_cnt - b0, 32'd0);
    check_val("masked_strobes", (spd_cnt - s0) + (we_cnt - w0) + (ld_cnt - l0), 32'd0);

    // Unmasked IRQ held off while not at an instruction boundary
    instr_bound = 1'b0; i_flag = 1'b0;
    b0 = busy_cnt;
    repeat (5) step();
    check_val("nobound_busy", busy_cnt - b0, 32'd0);

    // IRQ entry
    set_sp(8'hFD);
    exp_write(16'h01FD, 8'h81); exp_write(16'h01FC, 8'h23); exp_write(16'h01FB, 8'h24);
    exp_load(16'h5678);
    b0 = busy_cnt; s0 = spd_cnt;
    instr_bound = 1'b1;
    step();
    irq_n = 1'b1;
    wait_done("irq");
    check_val("irq_busy_cycles", busy_cnt - b0, 32'd6);
    check_val("irq_sp_dec", spd_cnt - s0, 32'd3);
    step();
    check_val("irq_sp_after", {24'h0, sp_cur}, 32'hFA);

    // BRK and pending NMI at the same boundary: NMI vector, B set
    pch_cur = 8'h44; pcl_cur = 8'h55; p_in = 8'h81;
    exp_write(16'h01FA, 8'h44); exp_write(16'h01F9, 8'h55); exp_write(16'h01F8, 8'hB1);
    exp_load(16'hABCD);
    instr_bound = 1'b0; nmi_n = 1'b0;
    step();
    instr_bound = 1'b1; brk_req = 1'b1;
    step();
    brk_req = 1'b0;
    check_val("brknmi_busy", {31'h0, busy}, 32'h1);
    wait_done("brk_nmi");
    nmi_n = 1'b1;
    repeat (3) step();

    // NMI edge during an IRQ sequence is served at the next boundary
    pch_cur = 8'h90; pcl_cur = 8'h12; p_in = 8'h10;
    exp_write(16'h01F7, 8'h90); exp_write(16'h01F6, 8'h12); exp_write(16'h01F5, 8'h20);
    exp_load(16'h5678);
    exp_write(16'h01F4, 8'h90); exp_write(16'h01F3, 8'h12); exp_write(16'h01F2, 8'h20);
    exp_load(16'hABCD);
    irq_n = 1'b0;
    step();
    irq_n = 1'b1;
    step();
    nmi_n = 1'b0;
    wait_done("irq_then_nmi_a");
    wait_done("irq_then_nmi_b");
    nmi_n = 1'b1;
    step();
    check_val("nmi_sp_after", {24'h0, sp_cur}, 32'hF1);

    // Reset asserted in VEC_H aborts the IRQ sequence
    exp_write(16'h01F1, 8'h90); exp_write(16'h01F0, 8'h12); exp_write(16'h01EF, 8'h20);
    irq_n = 1'b0;
    step();
    irq_n = 1'b1;
    repeat (4) step();
    reset_n = 1'b0;
    #1;
    check_val("abort_busy", {31'h0, busy}, 32'h1);
    check_val("abort_strobes", {27'h0, mem_we, sp_dec, pc_load, set_i, done}, 32'h0);
    check_val("abort_vec", {16'h0, pch_load, pcl_load}, 32'h0);
    check_val("abort_sb_drained", sb.size(), 32'd0);
    repeat (2) step();
    exp_load(16'h1234);
    w0 = we_cnt;
    reset_n = 1'b1;
    wait_done("abort_reset");
    check_val("abort_reset_no_we", we_cnt - w0, 32'd0);
    repeat (2) step();

    check_val("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
